back_ground_bands: RTL and testbench

//  Parametrised banded-background generator for the VGA path.

---
 rtl/bg_pkg.sv | 33 +++
 rtl/bg_band_lookup.sv | 30 +++
 rtl/back_ground_bands.sv | 245 ++++++++++++++++++++++++
 tb/tb_back_ground_bands.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// ----------------------------------------------------------------------------
// bg_pkg : shared types and constants for the banded background generator.
// ----------------------------------------------------------------------------
package bg_pkg;

    // 8-bit colour: RRRGGGBB
    typedef logic [7:0] rgb332_t;

    // One band: last visible row (inclusive) and the colour painted above it
    typedef struct packed {
        logic [10:0] bottom;
        rgb332_t     color;
    } band_entry_t;

    // Shadow->active commit handshake
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    localparam rgb332_t BLANK_RGB = 8'h00;
    localparam rgb332_t RESET_RGB = 8'hFF;

    // Power-up bottom row of band idx: the frame split into equal slices
    function automatic logic [10:0] reset_bottom(input int idx,
                                                 input int frame_h,
                                                 input int num_bands);
        int b;
        b = (((idx + 1) * frame_h) / num_bands) - 1;
        return b[10:0];
    endfunction

endpackage

// File: rtl/bg_band_lookup.sv
// ----------------------------------------------------------------------------
// bg_band_lookup : combinational band search.
// Returns the colour of the lowest-index band whose bottom is at or below
// y_eff; bottoms need not be sorted. Falls back to DEFAULT_COLOR when the
// row lies beyond every band bottom.
// ----------------------------------------------------------------------------
module bg_band_lookup
    import bg_pkg::*;
#(
    parameter int      NUM_BANDS     = 4,
    parameter rgb332_t DEFAULT_COLOR = 8'h42
) (
    input  logic [10:0]                  y_eff,
    input  band_entry_t [NUM_BANDS-1:0]  bands,
    output rgb332_t                      color
);

    // Scan from the highest index down so the lowest matching index overwrites last
    always_comb begin
        color = DEFAULT_COLOR;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (y_eff <= bands[i].bottom) begin
                color = bands[i].color;
            end else begin
                color = color;
            end
        end
    end

endmodule

// File: rtl/back_ground_bands.sv
// ----------------------------------------------------------------------------
// back_ground_bands : banded background layer for the VGA path (RGB332).
//
// A shadow band table is written through the cfg_* port and copied to the
// active table only on startOfFrame after a commit request, so a frame is
// always drawn from a single consistent table.
//
// Build option: define BG_SCROLL_EN to enable vertical scrolling (one row
// every SCROLL_DIV frames). Without it the band rows are pixelY directly.
// ----------------------------------------------------------------------------
module back_ground_bands
    import bg_pkg::*;
#(
    parameter int         NUM_BANDS     = 4,
    parameter int         FRAME_W       = 640,
    parameter int         FRAME_H       = 480,
    parameter logic [7:0] DEFAULT_COLOR = 8'h42,
    parameter int         SCROLL_DIV    = 4,
    localparam int        IW            = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   pixelX,
    input  logic [10:0]   pixelY,
    input  logic          startOfFrame,
    input  logic          cfg_wr,
    input  logic [IW-1:0] cfg_idx,
    input  logic [10:0]   cfg_bottom,
    input  logic [7:0]    cfg_color,
    input  logic          cfg_commit,
    output logic          cfg_ready,
    output logic          cfg_done,
    output logic [7:0]    BG_RGB
);

    localparam logic [10:0] FRAME_W_11 = 11'(FRAME_W);
    localparam logic [10:0] FRAME_H_11 = 11'(FRAME_H);

    // Elaboration-time parameter sanity
    if ((NUM_BANDS < 2) || (NUM_BANDS > 16) || (SCROLL_DIV < 1)) begin : g_param_check
        $error("back_ground_bands: NUM_BANDS must be 2..16 and SCROLL_DIV >= 1");
    end

    band_entry_t [NUM_BANDS-1:0] shadow_r;
    band_entry_t [NUM_BANDS-1:0] active_r;
    band_entry_t [NUM_BANDS-1:0] table_sel_s;

    cfg_state_t state_r;
    cfg_state_t state_n_s;
    logic       copy_s;
    logic       wr_ok_s;
    logic       cfg_ready_r;
    logic       cfg_done_r;

    logic [10:0] y_eff_s;
    logic        blank_s;
    rgb332_t     lut_color_s;
    rgb332_t     bg_rgb_r;

    // ------------------------------------------------------------------
    // Config handshake
    // ------------------------------------------------------------------

    // Writes are only taken while the shadow is open (no commit outstanding)
    assign wr_ok_s = cfg_wr & cfg_ready_r;

    // Commit FSM next state; a commit seen in IDLE always waits for a later frame start
    always_comb begin
        state_n_s = state_r;
        copy_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_commit) begin
                    state_n_s = PENDING;
                end else begin
                    state_n_s = IDLE;
                end
            end
            PENDING: begin
                if (startOfFrame) begin
                    copy_s    = 1'b1;
                    state_n_s = IDLE;
                end else begin
                    state_n_s = PENDING;
                end
            end
            default: begin
                state_n_s = IDLE;
                copy_s    = 1'b0;
            end
        endcase
    end

    // Commit FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Registered handshake outputs: ready mirrors the next state, done marks the copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready_r <= 1'b1;
            cfg_done_r  <= 1'b0;
        end else begin
            cfg_ready_r <= (state_n_s == IDLE);
            cfg_done_r  <= copy_s;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign cfg_done  = cfg_done_r;

    // ------------------------------------------------------------------
    // Band tables
    // ------------------------------------------------------------------

    // Shadow table: reset slices, then per-entry writes; out-of-range indices never match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                shadow_r[i].bottom <= reset_bottom(i, FRAME_H, NUM_BANDS);
                shadow_r[i].color  <= DEFAULT_COLOR;
            end
        end else if (wr_ok_s) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (cfg_idx == IW'(i)) begin
                    shadow_r[i].bottom <= cfg_bottom;
                    shadow_r[i].color  <= cfg_color;
                end
            end
        end
    end

    // Active table: whole-table copy on the frame start that completes a commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                active_r[i].bottom <= reset_bottom(i, FRAME_H, NUM_BANDS);
                active_r[i].color  <= DEFAULT_COLOR;
            end
        end else if (copy_s) begin
            active_r <= shadow_r;
        end
    end

    // The frame-start pixel is already part of the new frame, so it sees the
    // table being copied rather than the one being retired
    assign table_sel_s = copy_s ? shadow_r : active_r;

    // ------------------------------------------------------------------
    // Row used for the band search
    // ------------------------------------------------------------------
`ifdef BG_SCROLL_EN
    localparam int              FCW        = $clog2(SCROLL_DIV) + 1;
    localparam logic [FCW-1:0]  DIV_LAST   = FCW'(SCROLL_DIV - 1);
    localparam logic [11:0]     FRAME_H_12 = 12'(FRAME_H);

    logic [FCW-1:0] frame_cnt_r;
    logic [FCW-1:0] frame_cnt_n_s;
    logic [10:0]    scroll_r;
    logic [10:0]    scroll_n_s;
    logic [11:0]    y_sum_s;
    logic [11:0]    y_wrap_s;

    // Scroll advance: one row every SCROLL_DIV frame starts, wrapping at the frame height
    always_comb begin
        frame_cnt_n_s = frame_cnt_r;
        scroll_n_s    = scroll_r;
        if (startOfFrame) begin
            if (frame_cnt_r == DIV_LAST) begin
                frame_cnt_n_s = {FCW{1'b0}};
                if (scroll_r == (FRAME_H_11 - 11'd1)) begin
                    scroll_n_s = 11'd0;
                end else begin
                    scroll_n_s = scroll_r + 11'd1;
                end
            end else begin
                frame_cnt_n_s = frame_cnt_r + FCW'(1);
                scroll_n_s    = scroll_r;
            end
        end else begin
            frame_cnt_n_s = frame_cnt_r;
            scroll_n_s    = scroll_r;
        end
    end

    // Scroll and frame counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= {FCW{1'b0}};
            scroll_r    <= 11'd0;
        end else begin
            frame_cnt_r <= frame_cnt_n_s;
            scroll_r    <= scroll_n_s;
        end
    end

    // Scrolled row, folded back into 0..FRAME_H-1 with 12-bit headroom
    always_comb begin
        y_sum_s = {1'b0, pixelY} + {1'b0, scroll_n_s};
        if (y_sum_s >= FRAME_H_12) begin
            y_wrap_s = y_sum_s - FRAME_H_12;
        end else begin
            y_wrap_s = y_sum_s;
        end
        y_eff_s = y_wrap_s[10:0];
    end
`else
    assign y_eff_s = pixelY;
`endif

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------

    // Blanking uses the raw beam position, never the scrolled row
    assign blank_s = (pixelX >= FRAME_W_11) || (pixelY >= FRAME_H_11);

    bg_band_lookup #(
        .NUM_BANDS     (NUM_BANDS),
        .DEFAULT_COLOR (DEFAULT_COLOR)
    ) u_lookup (
        .y_eff (y_eff_s),
        .bands (table_sel_s),
        .color (lut_color_s)
    );

    // Output colour register: one pixel of latency from pixelX/pixelY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_rgb_r <= RESET_RGB;
        end else if (blank_s) begin
            bg_rgb_r <= BLANK_RGB;
        end else begin
            bg_rgb_r <= lut_color_s;
        end
    end

    assign BG_RGB = bg_rgb_r;

endmodule

// File: tb/tb_back_ground_bands.sv
// ----------------------------------------------------------------------------
// tb_back_ground_bands : directed, table-driven bench for back_ground_bands
// (NUM_BANDS=4, 640x480, DEFAULT_COLOR=8'h42, SCROLL_DIV=2).
// ----------------------------------------------------------------------------
module tb_back_ground_bands;

    logic        clk;
    logic        reset;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        cfg_wr;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_bottom;
    logic [7:0]  cfg_color;
    logic        cfg_commit;
    logic        cfg_ready;
    logic        cfg_done;
    logic [7:0]  BG_RGB;

    int errors;
    int checks;
    int sof_count;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [12];

    back_ground_bands #(
        .NUM_BANDS     (4),
        .FRAME_W       (640),
        .FRAME_H       (480),
        .DEFAULT_COLOR (8'h42),
        .SCROLL_DIV    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_bottom   (cfg_bottom),
        .cfg_color    (cfg_color),
        .cfg_commit   (cfg_commit),
        .cfg_ready    (cfg_ready),
        .cfg_done     (cfg_done),
        .BG_RGB       (BG_RGB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Raw pixelY that makes the band search see row yl under the current scroll
    function automatic logic [10:0] drive_y(input logic [10:0] yl);
        int s;
        int r;
        if (yl >= 11'd480) begin
            return yl;
        end
`ifdef BG_SCROLL_EN
        s = (sof_count / 2) % 480;
`else
        s = 0;
`endif
        r = (int'(yl) + 480 - s) % 480;
        return r[10:0];
    endfunction

    task automatic write_band(input logic [1:0] idx, input logic [10:0] bot, input logic [7:0] col);
        cfg_wr     = 1'b1;
        cfg_idx    = idx;
        cfg_bottom = bot;
        cfg_color  = col;
        tick();
        cfg_wr     = 1'b0;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        sof_count++;
    endtask

    task automatic pix(input string name, input logic [10:0] x, input logic [10:0] y,
                       input logic [7:0] exp);
        pixelX = x;
        pixelY = drive_y(y);
        tick();
        check8(name, BG_RGB, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        sof_count = 0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        sof_count    = 0;
        reset        = 1'b1;
        pixelX       = 11'd10;
        pixelY       = 11'd0;
        startOfFrame = 1'b0;
        cfg_wr       = 1'b0;
        cfg_idx      = 2'd0;
        cfg_bottom   = 11'd0;
        cfg_color    = 8'h00;
        cfg_commit   = 1'b0;

        vecs[0]  = '{11'd10,  11'd0,   8'h3E};
        vecs[1]  = '{11'd10,  11'd199, 8'h3E};
        vecs[2]  = '{11'd10,  11'd200, 8'h0E};
        vecs[3]  = '{11'd10,  11'd399, 8'h0E};
        vecs[4]  = '{11'd10,  11'd400, 8'hAE};
        vecs[5]  = '{11'd0,   11'd419, 8'hAE};
        vecs[6]  = '{11'd10,  11'd420, 8'hEE};
        vecs[7]  = '{11'd639, 11'd479, 8'hEE};
        vecs[8]  = '{11'd640, 11'd0,   8'h00};
        vecs[9]  = '{11'd10,  11'd500, 8'h00};
        vecs[10] = '{11'd10,  11'd480, 8'h00};
        vecs[11] = '{11'd2047,11'd2047,8'h00};

        // Reset state
        tick();
        tick();
        check8("reset_rgb", BG_RGB, 8'hFF);
        check1("reset_ready", cfg_ready, 1'b1);
        check1("reset_done", cfg_done, 1'b0);
        reset = 1'b0;

        // 1: default table sweep
        for (int y = 0; y < 480; y++) begin
            pix("sweep_default", 11'd10, 11'(y), 8'h42);
        end

        // 2: program, commit, frame start
        write_band(2'd0, 11'd199, 8'h3E);
        write_band(2'd1, 11'd399, 8'h0E);
        write_band(2'd2, 11'd419, 8'hAE);
        write_band(2'd3, 11'd479, 8'hEE);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check1("commit_ready_low", cfg_ready, 1'b0);
        pix("pre_sof_old_table", 11'd10, 11'd0, 8'h42);
        check1("no_done_before_sof", cfg_done, 1'b0);
        pulse_sof();
        check1("done_pulse", cfg_done, 1'b1);
        check1("ready_after_copy", cfg_ready, 1'b1);
        tick();
        check1("done_one_cycle", cfg_done, 1'b0);
        for (int i = 0; i < 12; i++) begin
            pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp);
        end

        // Latency: output holds between edges and follows one edge later
        pix("lat_a", 11'd10, 11'd0, 8'h3E);
        pixelY = drive_y(11'd200);
        #2;
        check8("lat_hold", BG_RGB, 8'h3E);
        tick();
        check8("lat_follow", BG_RGB, 8'h0E);

        // 3: commit pending blocks writes; old table stays until frame start
        write_band(2'd0, 11'd99, 8'hC3);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check1("pend_ready_low", cfg_ready, 1'b0);
        write_band(2'd1, 11'd0, 8'h11);
        pix("pend_old_y0", 11'd10, 11'd0, 8'h3E);
        pix("pend_old_y150", 11'd10, 11'd150, 8'h3E);
        pulse_sof();
        check1("pend_done", cfg_done, 1'b1);
        pix("new_y0", 11'd10, 11'd0, 8'hC3);
        pix("dropped_write_y150", 11'd10, 11'd150, 8'h0E);

        // 4: commit + frame start + write together -> copy waits for next frame start
        cfg_commit   = 1'b1;
        startOfFrame = 1'b1;
        cfg_wr       = 1'b1;
        cfg_idx      = 2'd1;
        cfg_bottom   = 11'd149;
        cfg_color    = 8'h55;
        tick();
        cfg_commit   = 1'b0;
        startOfFrame = 1'b0;
        cfg_wr       = 1'b0;
        sof_count++;
        check1("same_cycle_no_done", cfg_done, 1'b0);
        check1("same_cycle_pending", cfg_ready, 1'b0);
        pix("same_cycle_old_y120", 11'd10, 11'd120, 8'h0E);
        check1("same_cycle_still_no_done", cfg_done, 1'b0);
        pulse_sof();
        check1("next_sof_done", cfg_done, 1'b1);
        pix("next_sof_new_y120", 11'd10, 11'd120, 8'h55);
        pix("next_sof_y200", 11'd10, 11'd200, 8'hAE);

        // 5: reset in the middle of a pending commit
        write_band(2'd3, 11'd5, 8'h77);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check1("pre_reset_pending", cfg_ready, 1'b0);
        reset = 1'b1;
        #2;
        check8("async_reset_rgb", BG_RGB, 8'hFF);
        check1("async_reset_ready", cfg_ready, 1'b1);
        check1("async_reset_done", cfg_done, 1'b0);
        tick();
        reset     = 1'b0;
        sof_count = 0;
        pix("post_reset_y0", 11'd10, 11'd0, 8'h42);
        pix("post_reset_y300", 11'd10, 11'd300, 8'h42);
        pix("post_reset_blank", 11'd700, 11'd10, 8'h00);
        pulse_sof();
        check1("discarded_commit_no_done", cfg_done, 1'b0);
        pix("discarded_commit_y0", 11'd10, 11'd0, 8'h42);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        pulse_sof();
        check1("shadow_default_done", cfg_done, 1'b1);
        pix("shadow_default_y0", 11'd10, 11'd0, 8'h42);
        pix("shadow_default_y150", 11'd10, 11'd150, 8'h42);

`ifdef BG_SCROLL_EN
        // 6: scrolling
        do_reset();
        write_band(2'd0, 11'd9, 8'h3E);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_sof();
        end
        pixelX = 11'd10;
        pixelY = 11'd7;
        tick();
        check8("scroll2_y7", BG_RGB, 8'h3E);
        pixelY = 11'd8;
        tick();
        check8("scroll2_y8", BG_RGB, 8'h42);
        for (int i = 0; i < 954; i++) begin
            pulse_sof();
        end
        pixelY = 11'd1;
        tick();
        check8("scroll479_y1", BG_RGB, 8'h3E);
        pixelY = 11'd0;
        tick();
        check8("scroll479_y0", BG_RGB, 8'h42);
        pixelY = 11'd10;
        tick();
        check8("scroll479_y10", BG_RGB, 8'h3E);
        pixelY = 11'd11;
        tick();
        check8("scroll479_y11", BG_RGB, 8'h42);
        pixelY = 11'd479;
        pixelX = 11'd640;
        tick();
        check8("scroll_blank_raw", BG_RGB, 8'h00);
        pixelX = 11'd10;
        pulse_sof();
        pulse_sof();
        pixelY = 11'd9;
        tick();
        check8("scroll_wrap_y9", BG_RGB, 8'h3E);
        pixelY = 11'd10;
        tick();
        check8("scroll_wrap_y10", BG_RGB, 8'h42);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
